// File: rtl/debug_cmd_rx.sv
// debug_cmd_rx: host debug command decoder behind the board UART receiver.
// Drives breakpoint, halt/step and clock-select controls; optional ACK/NAK
// byte per command when DEBUG_ACK_EN is defined.
// Ports: clk, reset (async, active-high); received/rx_byte/recv_error in;
// bp_addr, bp_en, halt, step, clk_sel, cmd_done, err_count,
// ack_strobe, ack_byte out (all registered).
module debug_cmd_rx #(
  parameter int TIMEOUT_CYCLES = 6_600_000,
  parameter int TW             = 23
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        received,
  input  logic [7:0]  rx_byte,
  input  logic        recv_error,
  output logic [15:0] bp_addr,
  output logic        bp_en,
  output logic        halt,
  output logic        step,
  output logic        clk_sel,
  output logic        cmd_done,
  output logic [7:0]  err_count,
  output logic        ack_strobe,
  output logic [7:0]  ack_byte
);

  typedef enum logic [1:0] {
    IDLE, ARG_LO, ARG_HI, ARG_M
  } state_t;

  localparam logic [TW-1:0] TMO_LAST =
    TW'(TIMEOUT_CYCLES - 1);

  state_t        state;
  logic [7:0]    shadow_lo;
  logic [TW-1:0] tmo_cnt;

  logic rx;
  logic tmo;
  logic op_ok;
  logic op_rej;
  logic done;
  logic rej;

  always_comb begin
    // A framing error always discards the byte.
    rx     = received & ~recv_error;
    // A byte arriving on the timeout cycle wins over the timeout.
    tmo    = (state != IDLE) && !received &&
             (tmo_cnt == TMO_LAST);
    op_ok  = 1'b0;
    op_rej = 1'b0;
    if (rx && state == IDLE) begin
      unique case (rx_byte)
        8'h42, 8'h4D: ;
        8'h43, 8'h48, 8'h52: op_ok = 1'b1;
        8'h53: begin
          op_ok  = halt;
          op_rej = ~halt;
        end
        default: op_rej = 1'b1;
      endcase
    end
    done = op_ok |
           (rx && (state == ARG_HI || state == ARG_M));
    rej  = recv_error | tmo | op_rej;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shadow_lo <= 8'h00;
      tmo_cnt   <= '0;
      bp_addr   <= 16'h0000;
      bp_en     <= 1'b0;
      halt      <= 1'b0;
      step      <= 1'b0;
      clk_sel   <= 1'b0;
      cmd_done  <= 1'b0;
      err_count <= 8'h00;
    end else begin
      step     <= rx && state == IDLE &&
                  rx_byte == 8'h53 && halt;
      cmd_done <= done;
      if (rej && err_count != 8'hFF)
        err_count <= err_count + 8'h01;
      if (rx || rej || state == IDLE)
        tmo_cnt <= '0;
      else
        tmo_cnt <= tmo_cnt + TW'(1);
      if (rej) begin
        state <= IDLE;
      end else if (rx) begin
        unique case (state)
          IDLE: begin
            unique case (rx_byte)
              8'h42: state <= ARG_LO;
              8'h4D: state <= ARG_M;
              8'h43: bp_en <= 1'b0;
              8'h48: halt  <= 1'b1;
              8'h52: halt  <= 1'b0;
              default: ;
            endcase
          end
          ARG_LO: begin
            shadow_lo <= rx_byte;
            state     <= ARG_HI;
          end
          ARG_HI: begin
            bp_addr <= {rx_byte, shadow_lo};
            bp_en   <= 1'b1;
            state   <= IDLE;
          end
          ARG_M: begin
            clk_sel <= rx_byte[0];
            state   <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef DEBUG_ACK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_strobe <= 1'b0;
      ack_byte   <= 8'h00;
    end else begin
      ack_strobe <= done | rej;
      if (done)
        ack_byte <= 8'h06;
      else if (rej)
        ack_byte <= 8'h15;
    end
  end
`else
  assign ack_strobe = 1'b0;
  assign ack_byte   = 8'h00;
`endif

endmodule

// File: tb/tb_debug_cmd_rx.sv
// tb_debug_cmd_rx: scoreboard bench for debug_cmd_rx.
// Expected outputs are queued per byte and checked the cycle after.
module tb_debug_cmd_rx;

  localparam int T  = 20;
  localparam int TW = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        received = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        recv_error = 1'b0;
  logic [15:0] bp_addr;
  logic        bp_en, halt, step, clk_sel, cmd_done;
  logic [7:0]  err_count;
  logic        ack_strobe;
  logic [7:0]  ack_byte;

  debug_cmd_rx #(.TIMEOUT_CYCLES(T), .TW(TW)) dut (
    .clk(clk), .reset(reset),
    .received(received), .rx_byte(rx_byte),
    .recv_error(recv_error),
    .bp_addr(bp_addr), .bp_en(bp_en), .halt(halt),
    .step(step), .clk_sel(clk_sel), .cmd_done(cmd_done),
    .err_count(err_count),
    .ack_strobe(ack_strobe), .ack_byte(ack_byte)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic        en, hlt, cs, done, stp, ack;
    logic [7:0]  err, ackb;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  logic [15:0] m_addr;
  logic        m_en, m_halt, m_cs;
  logic [7:0]  m_err, m_lo, m_ackb;
  int          m_st;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_addr = 16'h0; m_en = 0; m_halt = 0; m_cs = 0;
    m_err = 8'h0; m_lo = 8'h0; m_ackb = 8'h0; m_st = 0;
  endtask

  task automatic model_rej();
    if (m_err != 8'hFF) m_err = m_err + 8'h1;
    m_st = 0;
    m_ackb = 8'h15;
  endtask

  task automatic model(input logic [7:0] b, input bit e);
    exp_t x;
    bit done = 0, stp = 0, rej = 0;
    if (e) rej = 1;
    else case (m_st)
      0: case (b)
        8'h42: m_st = 1;
        8'h4D: m_st = 3;
        8'h43: begin m_en = 0; done = 1; end
        8'h48: begin m_halt = 1; done = 1; end
        8'h52: begin m_halt = 0; done = 1; end
        8'h53: if (m_halt) begin stp = 1; done = 1; end
               else rej = 1;
        default: rej = 1;
      endcase
      1: begin m_lo = b; m_st = 2; end
      2: begin m_addr = {b, m_lo}; m_en = 1; done = 1; m_st = 0; end
      default: begin m_cs = b[0]; done = 1; m_st = 0; end
    endcase
    if (rej) model_rej();
    if (done) m_ackb = 8'h06;
    x.addr = m_addr; x.en = m_en; x.hlt = m_halt; x.cs = m_cs;
    x.done = done; x.stp = stp; x.ack = done | rej;
    x.err = m_err; x.ackb = m_ackb;
    sb.push_back(x);
  endtask

  // Assumes we are at a negedge; returns at the next negedge.
  task automatic send(input logic [7:0] b, input bit e = 0);
    model(b, e);
    rx_byte = b; received = 1'b1; recv_error = e;
    @(negedge clk);
    received = 1'b0; recv_error = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  exp_t e;
  bit   s;
  always @(posedge clk) begin
    s = (received || recv_error) && !reset;
    #1;
    if (s) begin
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        e = sb.pop_front();
        chk("bp_addr", bp_addr, e.addr);
        chk("bp_en", bp_en, e.en);
        chk("halt", halt, e.hlt);
        chk("clk_sel", clk_sel, e.cs);
        chk("cmd_done", cmd_done, e.done);
        chk("step", step, e.stp);
        chk("err_count", err_count, e.err);
`ifdef DEBUG_ACK_EN
        chk("ack_strobe", ack_strobe, e.ack);
        chk("ack_byte", ack_byte, e.ackb);
`else
        chk("ack_strobe", ack_strobe, 0);
        chk("ack_byte", ack_byte, 0);
`endif
      end
    end else if (!reset) begin
      chk("idle_done", cmd_done, 0);
      chk("idle_step", step, 0);
    end
  end

  initial begin
    model_reset();
    idle(3);
    chk("rst_bp_addr", bp_addr, 16'h0);
    chk("rst_bp_en", bp_en, 0);
    chk("rst_halt", halt, 0);
    chk("rst_clk_sel", clk_sel, 0);
    chk("rst_err", err_count, 0);
    chk("rst_ack", {ack_strobe, ack_byte}, 0);
    reset = 1'b0;
    idle(2);

    send(8'h42); send(8'h34); send(8'h12);
    chk("bp_1234", {bp_en, bp_addr}, {1'b1, 16'h1234});

    send(8'h53);
    chk("s_running_err", err_count, 8'd1);
    send(8'h48); send(8'h53);
    idle(2);
    chk("halted", halt, 1);

    send(8'h42); send(8'hAA);
    repeat (T - 1) @(posedge clk);
    #1 chk("tmo_early", err_count, 8'd1);
    @(posedge clk);
    #1 chk("tmo_err", err_count, 8'd2);
    chk("tmo_addr", bp_addr, 16'h1234);
`ifdef DEBUG_ACK_EN
    chk("tmo_nak", {ack_strobe, ack_byte}, {1'b1, 8'h15});
`endif
    model_rej();
    @(negedge clk);
    send(8'h4D); send(8'h01);
    chk("clk_sel_1", clk_sel, 1);

    send(8'h42); send(8'h55, 1);
    send(8'h42); send(8'h78); send(8'h56);
    chk("bp_5678", bp_addr, 16'h5678);

    send(8'h42, 1);
    send(8'h43);
    chk("bp_clear", bp_en, 0);

    for (int i = 0; i < 300; i++) send(8'h00);
    chk("err_sat", err_count, 8'hFF);

    send(8'h42); send(8'h11);
    reset = 1'b1;
    #1;
    chk("mid_rst_outs",
        {bp_addr, bp_en, halt, clk_sel, cmd_done, step},
        0);
    chk("mid_rst_err", err_count, 0);
    chk("mid_rst_ack", {ack_strobe, ack_byte}, 0);
    idle(3);
    reset = 1'b0;
    model_reset();
    idle(2);
    send(8'h22);
    chk("post_rst_idle", err_count, 8'd1);
    send(8'h48); send(8'h52);
    idle(3);
    chk("sb_drain", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
